// File: rtl/sa_tile_scheduler_pkg.sv
// Shared types for the systolic-array tile scheduler: one-hot FSM encoding
// and the default SRAM word-address width.
package sa_tile_scheduler_pkg;

   localparam int SA_ADDR_WIDTH = 16;

   localparam int SCHED_IDLE_B      = 0;
   localparam int SCHED_LOAD_B      = 1;
   localparam int SCHED_ISSUE_B     = 2;
   localparam int SCHED_WAIT_COMP_B = 3;
   localparam int SCHED_ISSUE_WB_B  = 4;
   localparam int SCHED_WAIT_WB_B   = 5;
   localparam int SCHED_FINI_B      = 6;

   typedef enum logic [6:0] {
      SCHED_IDLE      = 7'b000_0001,
      SCHED_LOAD      = 7'b000_0010,
      SCHED_ISSUE     = 7'b000_0100,
      SCHED_WAIT_COMP = 7'b000_1000,
      SCHED_ISSUE_WB  = 7'b001_0000,
      SCHED_WAIT_WB   = 7'b010_0000,
      SCHED_FINI      = 7'b100_0000
   } sa_sched_state_t;

endpackage

// File: rtl/sa_tile_addr_gen.sv
// Tile counters and incremental base-address accumulators for the tile
// scheduler; tile counts are ceil(dim/TILE_DIM) by round-up-and-shift.
module sa_tile_addr_gen
   import sa_tile_scheduler_pkg::*;
#(
   parameter int TILE_DIM   = 2,
   parameter int ADDR_WIDTH = SA_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  init,
   input  logic                  step,
   input  logic [31:0]           m,
   input  logic [31:0]           n,
   input  logic [ADDR_WIDTH-1:0] k_addr,
   output logic [ADDR_WIDTH-1:0] row_base,
   output logic [ADDR_WIDTH-1:0] col_base,
   output logic [ADDR_WIDTH-1:0] out_base,
   output logic                  last
);

   localparam int TILE_SHIFT = $clog2(TILE_DIM);

   logic [31:0]           mt_q, nt_q, mt_last_q, nt_last_q;
   logic [ADDR_WIDTH-1:0] stride_k_q, stride_n_q;
   logic [ADDR_WIDTH-1:0] row_q, col_q, out_row_q, out_col_q;
   logic [32:0]           m_round, n_round;

   // 33-bit sums so a dimension near 2^32 cannot wrap before the shift
   assign m_round = {1'b0, m} + 33'(TILE_DIM - 1);
   assign n_round = {1'b0, n} + 33'(TILE_DIM - 1);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         mt_q       <= '0;
         nt_q       <= '0;
         mt_last_q  <= '0;
         nt_last_q  <= '0;
         stride_k_q <= '0;
         stride_n_q <= '0;
         row_q      <= '0;
         col_q      <= '0;
         out_row_q  <= '0;
         out_col_q  <= '0;
      end else if (init) begin
         mt_q       <= '0;
         nt_q       <= '0;
         mt_last_q  <= 32'((m_round >> TILE_SHIFT) - 33'd1);
         nt_last_q  <= 32'((n_round >> TILE_SHIFT) - 33'd1);
         stride_k_q <= k_addr << TILE_SHIFT;
         stride_n_q <= ADDR_WIDTH'(n) << TILE_SHIFT;
         row_q      <= '0;
         col_q      <= '0;
         out_row_q  <= '0;
         out_col_q  <= '0;
      end else if (step) begin
         if (nt_q == nt_last_q) begin
            nt_q      <= '0;
            mt_q      <= mt_q + 32'd1;
            col_q     <= '0;
            out_col_q <= '0;
            row_q     <= row_q + stride_k_q;
            out_row_q <= out_row_q + stride_n_q;
         end else begin
            nt_q      <= nt_q + 32'd1;
            col_q     <= col_q + stride_k_q;
            out_col_q <= out_col_q + ADDR_WIDTH'(TILE_DIM);
         end
      end
   end

   assign row_base = row_q;
   assign col_base = col_q;
   assign out_base = out_row_q + out_col_q;
   assign last     = (mt_q == mt_last_q) && (nt_q == nt_last_q);

endmodule

// File: rtl/sa_tile_scheduler.sv
// Walks an MxNxK GEMM tile by tile (mt outer, nt inner), issuing compute
// and writeback for each tile and pulsing done (with err) at the end.
//
// state     | meaning
// IDLE      | waiting for start
// LOAD      | latch dimensions, initialise counters/accumulators
// ISSUE     | tile_start pulse, bases valid
// WAIT_COMP | waiting for tile_done
// ISSUE_WB  | wb_start pulse
// WAIT_WB   | waiting for wb_done; advance or finish
// FINI      | done pulse (err if a dimension was zero)
module sa_tile_scheduler
   import sa_tile_scheduler_pkg::*;
#(
   parameter int TILE_DIM   = 2,
   parameter int ADDR_WIDTH = SA_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [31:0]           M,
   input  logic [31:0]           N,
   input  logic [31:0]           K,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  tile_start,
   output logic [ADDR_WIDTH-1:0] tile_row_base,
   output logic [ADDR_WIDTH-1:0] tile_col_base,
   output logic [31:0]           tile_k,
   input  logic                  tile_done,
   output logic                  wb_start,
   output logic [ADDR_WIDTH-1:0] wb_out_base,
   input  logic                  wb_done
);

   sa_sched_state_t state_q, state_d;
   logic            err_q;
   logic [31:0]     tile_k_q;
   logic            ag_init, ag_step, ag_last;
   logic            dims_zero;

   assign dims_zero = (M == 32'd0) || (N == 32'd0) || (K == 32'd0);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= SCHED_IDLE;
         err_q    <= 1'b0;
         tile_k_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == SCHED_LOAD) begin
            err_q    <= dims_zero;
            tile_k_q <= K;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ag_init = 1'b0;
      ag_step = 1'b0;
      case (state_q)
         SCHED_IDLE:      if (start) state_d = SCHED_LOAD;
         SCHED_LOAD: begin
            ag_init = 1'b1;
            state_d = dims_zero ? SCHED_FINI : SCHED_ISSUE;
         end
         SCHED_ISSUE:     state_d = SCHED_WAIT_COMP;
         SCHED_WAIT_COMP: if (tile_done) state_d = SCHED_ISSUE_WB;
         SCHED_ISSUE_WB:  state_d = SCHED_WAIT_WB;
         SCHED_WAIT_WB: begin
            if (wb_done) begin
               if (ag_last) begin
                  state_d = SCHED_FINI;
               end else begin
                  state_d = SCHED_ISSUE;
                  ag_step = 1'b1;
               end
            end
         end
         SCHED_FINI:      state_d = SCHED_IDLE;
         default:         state_d = SCHED_IDLE;
      endcase
   end

   sa_tile_addr_gen #(
      .TILE_DIM   (TILE_DIM),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .clk      (clk),
      .rstn     (rstn),
      .init     (ag_init),
      .step     (ag_step),
      .m        (M),
      .n        (N),
      .k_addr   (ADDR_WIDTH'(K)),
      .row_base (tile_row_base),
      .col_base (tile_col_base),
      .out_base (wb_out_base),
      .last     (ag_last)
   );

   assign busy       = (state_q != SCHED_IDLE);
   assign done       = (state_q == SCHED_FINI);
   assign err        = (state_q == SCHED_FINI) && err_q;
   assign tile_start = (state_q == SCHED_ISSUE);
   assign wb_start   = (state_q == SCHED_ISSUE_WB);
   assign tile_k     = tile_k_q;

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Randomised bench for sa_tile_scheduler: a responder acks compute and
// writeback after random delays; tile order and bases come from a plain
// arithmetic model of the tiling.
module tb_sa_tile_scheduler;

   localparam int TD = 2;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [31:0]   M = '0, N = '0, K = '0;
   logic          busy, done, err, tile_start, wb_start;
   logic [AW-1:0] tile_row_base, tile_col_base, wb_out_base;
   logic [31:0]   tile_k;
   logic          tile_done = 1'b0, wb_done = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   sa_tile_scheduler #(.TILE_DIM(TD), .ADDR_WIDTH(AW)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .start         (start),
      .M             (M),
      .N             (N),
      .K             (K),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .tile_start    (tile_start),
      .tile_row_base (tile_row_base),
      .tile_col_base (tile_col_base),
      .tile_k        (tile_k),
      .tile_done     (tile_done),
      .wb_start      (wb_start),
      .wb_out_base   (wb_out_base),
      .wb_done       (wb_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: tile idx -> (mt, nt) with nt fastest, bases by multiplication
   function automatic logic [AW-1:0] ref_row(input int idx, input int nt_n, input int k);
      logic [31:0] v;
      v = (idx / nt_n) * TD * k;
      return v[AW-1:0];
   endfunction

   function automatic logic [AW-1:0] ref_col(input int idx, input int nt_n, input int k);
      logic [31:0] v;
      v = (idx % nt_n) * TD * k;
      return v[AW-1:0];
   endfunction

   function automatic logic [AW-1:0] ref_out(input int idx, input int nt_n, input int n);
      logic [31:0] v;
      v = (idx / nt_n) * TD * n + (idx % nt_n) * TD;
      return v[AW-1:0];
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_tstart"}, 64'(tile_start), 64'd0);
      chk({tag, "_wbstart"}, 64'(wb_start), 64'd0);
      chk({tag, "_row"}, 64'(tile_row_base), 64'd0);
      chk({tag, "_col"}, 64'(tile_col_base), 64'd0);
      chk({tag, "_out"}, 64'(wb_out_base), 64'd0);
      chk({tag, "_k"}, 64'(tile_k), 64'd0);
   endtask

   // One GEMM; abort_tile >= 0 pulses rstn during that tile's WAIT_WB
   task automatic run_gemm(input int m, input int n, input int k,
                           input bit misuse, input int abort_tile);
      int  mt_n, nt_n, total, issued, wbs, comp_wait, wb_wait;
      bit  exp_ts, exp_wb, exp_done, in_comp, in_wb, misuse_hit, abort_now, finished;
      mt_n = (m + TD - 1) / TD;
      nt_n = (n + TD - 1) / TD;
      total = mt_n * nt_n;
      issued = 0; wbs = 0; comp_wait = 0; wb_wait = 0;
      in_comp = 0; in_wb = 0; misuse_hit = 0; abort_now = 0; finished = 0;

      @(negedge clk);
      M = m; N = n; K = k; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("load_busy", 64'(busy), 64'd1);
      chk("load_tstart", 64'(tile_start), 64'd0);
      @(negedge clk);
      if (m == 0 || n == 0 || k == 0) begin
         chk("err_done", 64'(done), 64'd1);
         chk("err_err", 64'(err), 64'd1);
         chk("err_tstart", 64'(tile_start), 64'd0);
         @(negedge clk);
         chk("err_busy_after", 64'(busy), 64'd0);
         chk("err_done_after", 64'(done), 64'd0);
         chk("err_tstart_after", 64'(tile_start), 64'd0);
         chk("err_wbstart_after", 64'(wb_start), 64'd0);
         return;
      end

      exp_ts = 1; exp_wb = 0; exp_done = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         chk("tile_start", 64'(tile_start), 64'(exp_ts));
         chk("wb_start", 64'(wb_start), 64'(exp_wb));
         chk("done", 64'(done), 64'(exp_done));
         if (exp_done) begin
            chk("fin_err", 64'(err), 64'd0);
            chk("fin_tiles", 64'(issued), 64'(total));
            @(negedge clk);
            chk("fin_busy_after", 64'(busy), 64'd0);
            chk("fin_done_after", 64'(done), 64'd0);
            finished = 1;
            break;
         end
         exp_ts = 0; exp_wb = 0;
         tile_done = 1'b0; wb_done = 1'b0; start = 1'b0;

         if (tile_start) begin
            chk("row_base", 64'(tile_row_base), 64'(ref_row(issued, nt_n, k)));
            chk("col_base", 64'(tile_col_base), 64'(ref_col(issued, nt_n, k)));
            chk("tile_k", 64'(tile_k), 64'(k));
            issued++;
            comp_wait = misuse ? $urandom_range(2, 4) : $urandom_range(1, 4);
            in_comp = 1; misuse_hit = 0;
         end else if (in_comp) begin
            comp_wait--;
            if (comp_wait == 0) begin
               tile_done = 1'b1;
               exp_wb = 1;
               in_comp = 0;
            end else if (misuse && !misuse_hit) begin
               start = 1'b1;
               wb_done = 1'b1;
               misuse_hit = 1;
            end
         end

         if (wb_start) begin
            chk("out_base", 64'(wb_out_base), 64'(ref_out(issued - 1, nt_n, n)));
            chk("row_hold", 64'(tile_row_base), 64'(ref_row(issued - 1, nt_n, k)));
            wbs++;
            wb_wait = $urandom_range(1, 4);
            in_wb = 1; misuse_hit = 0;
            abort_now = (abort_tile == issued - 1);
         end else if (in_wb) begin
            if (abort_now) begin
               rstn = 1'b0;
               @(negedge clk);
               rstn = 1'b1;
               chk_all_zero("abort");
               for (int i = 0; i < 4; i++) begin
                  @(negedge clk);
                  chk("abort_no_done", 64'(done), 64'd0);
                  chk("abort_idle", 64'(busy), 64'd0);
               end
               return;
            end
            wb_wait--;
            if (wb_wait == 0) begin
               wb_done = 1'b1;
               in_wb = 0;
               if (wbs == total) exp_done = 1;
               else exp_ts = 1;
            end else if (misuse && !misuse_hit) begin
               tile_done = 1'b1;
               misuse_hit = 1;
            end
         end
         @(negedge clk);
      end
      tile_done = 1'b0; wb_done = 1'b0; start = 1'b0;
      if (!finished) chk("timeout", 64'd0, 64'd1);
   endtask

   initial begin
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);

      run_gemm(2, 2, 2, 0, -1);
      run_gemm(4, 4, 3, 0, -1);
      run_gemm(3, 5, 2, 0, -1);
      run_gemm(4, 4, 0, 0, -1);
      run_gemm(0, 4, 3, 0, -1);
      run_gemm(4, 0, 3, 0, -1);
      run_gemm(4, 4, 3, 1, -1);
      run_gemm(5, 3, 7, 1, -1);
      run_gemm(4, 4, 3, 0, 1);
      run_gemm(4, 4, 3, 0, -1);
      run_gemm(1, 1, 1, 0, -1);
      run_gemm(20, 4, 5000, 0, -1);
      for (int r = 0; r < 15; r++) begin
         int rm, rn, rk;
         bit mis;
         rm = $urandom_range(1, 7);
         rn = $urandom_range(1, 7);
         rk = $urandom_range(1, 40);
         mis = ($urandom_range(0, 3) == 0);
         run_gemm(rm, rn, rk, mis, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sa_tile_scheduler.md
# sa_tile_scheduler

Sequences the systolic array over a full M×N×K matrix multiply by breaking the output into TILE_DIM×TILE_DIM tiles. For each tile it hands base addresses and the reduction length K to the row and column fifo datapaths. It waits for the tile's compute and its output writeback to finish before moving on. It sits between the accelerator top-level FSM (start/done) and the systolic-array datapath and output writeback logic.

## Interface
- TILE_DIM, 2, systolic array edge length (power of two ≥ 2)
- ADDR_WIDTH, 16, SRAM word-address width of all buffers
- clk  in  1  clock
- rstn  in  1  reset: synchronous, active-low
- start  in  1  one-cycle request to begin a GEMM; honoured only in IDLE
- M, N, K  in  32 each  matrix dimensions; latched in LOAD
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a GEMM, including the error case
- err  out  1  valid with done: 1 means a dimension was zero
- tile_start  out  1  one-cycle pulse: compute one tile
- tile_row_base  out  ADDR_WIDTH  input-buffer base address of the tile
- tile_col_base  out  ADDR_WIDTH  weight-buffer base address of the tile
- tile_k  out  32  reduction length for the tile (= latched K)
- tile_done  in  1  datapath finished the tile; sampled only in WAIT_COMP
- wb_start  out  1  one-cycle pulse: write back the tile results
- wb_out_base  out  ADDR_WIDTH  output-buffer base address of the tile
- wb_done  in  1  writeback finished; sampled only in WAIT_WB

## Operation
- Memory layouts:
  - Input is M×K, row-major.
  - Weight is stored transposed as N×K, row-major.
  - Output is M×N, row-major.
- Tile counts: MT = ceil(M/TILE_DIM), NT = ceil(N/TILE_DIM). Both are computed in LOAD by shift and add; no divider.
- Tile order: mt outer, nt inner, each counting from 0.
- Tile addresses:
  - row_base = mt·TILE_DIM·K
  - col_base = nt·TILE_DIM·K
  - out_base = mt·TILE_DIM·N + nt·TILE_DIM
- Address arithmetic:
  - Implemented with incremental accumulators. Stride TILE_DIM·K is added per nt/mt step and TILE_DIM·N per mt step; no multipliers.
  - On nt wrap, the col accumulator resets to 0.
  - All address results are truncated to ADDR_WIDTH; overflow is not flagged.
- States (one-hot): IDLE, LOAD, ISSUE, WAIT_COMP, ISSUE_WB, WAIT_WB, FINI.
- State transitions:
  - IDLE→LOAD on start.
  - LOAD→FINI (err=1) if M, N or K is 0; otherwise LOAD→ISSUE.
  - ISSUE→WAIT_COMP unconditionally.
  - WAIT_COMP→ISSUE_WB on tile_done.
  - ISSUE_WB→WAIT_WB unconditionally.
  - WAIT_WB→FINI on wb_done if this is the last tile (mt=MT-1, nt=NT-1).
  - WAIT_WB→ISSUE on wb_done otherwise; counters and accumulators advance on that same edge.
  - FINI→IDLE unconditionally.
- Ignored inputs:
  - start is ignored while busy.
  - tile_done and wb_done arriving in any other state are ignored; they are not queued.
- Reset mid-operation: the next clk edge with rstn=0 forces IDLE and clears all counters and outputs. No partial done is issued.

## Timing
- Reset values: busy, done, err, tile_start and wb_start are 0. tile_row_base, tile_col_base, wb_out_base and tile_k are 0.
- All outputs are registered (driven from state/registers, no input-to-output combinational path).
- start sampled high at edge t → LOAD during cycle t+1 → ISSUE during cycle t+2.
  - tile_start is high exactly during the ISSUE cycle.
  - The address outputs are valid in that same cycle and held stable until the next ISSUE.
- tile_done sampled at edge u → wb_start is high during cycle u+1; wb_out_base is stable at that point.
- Overhead between the last wb_done of one tile and the next tile_start: 1 cycle (WAIT_WB→ISSUE).
- Final wb_done sampled at edge v → done is high during cycle v+1 (FINI) → busy is low from cycle v+2.
- Error path: start at t → done=err=1 during cycle t+2.
- tile_done asserted in the same cycle as tile_start is not sampled; it must arrive in WAIT_COMP.

## Structure
- systolic_array_pkg gains:
  - sa_sched_state_t: one-hot enum with _B bit-index constants, matching systolic_array_state_t.
  - The SCHED_IDLE…SCHED_FINI values.
- ADDR_WIDTH default comes from single_port_ram_pkg.
- One sub-module is natural: sa_tile_addr_gen. It holds the mt/nt counters and the three address accumulators, with init/step/last ports. The FSM stays in sa_tile_scheduler.

## Test plan
- M=N=K=2, datapath acks after 3 cycles → one tile_start with bases (0,0), wb_out_base 0, one wb_start, then done=1, err=0.
- M=N=4, K=3 → 4 tiles. (row, col, out) bases in order: (0,0,0), (0,6,2), (6,0,8), (6,6,10); tile_k=3 on each.
- M=3, N=5, K=2 → 6 tiles (MT=2, NT=3). Last tile bases: row 4, col 8, out 14. done follows the 6th wb_done by 1 cycle.
- K=0 (M=N=4) → no tile_start/wb_start; done=err=1 two cycles after start; busy low the next cycle.
- Protocol misuse:
  - start pulsed during WAIT_COMP → ignored; tile count unchanged.
  - wb_done pulsed during WAIT_COMP → ignored; the FSM still waits for tile_done.
- rstn low for 1 cycle during WAIT_WB of tile 2 → IDLE, all outputs 0, no done. A fresh start then runs the full sequence from tile (0,0).
